// File: rtl/rec_tq_pkg.sv
// Shared constants for the transform reconstruction path: widths, size codes,
// the per-mode shift table and the FIFO word layout of the round/clip stage.
package rec_tq_pkg;

    localparam int IN_W    = 28;
    localparam int OUT_W   = 16;
    localparam int SUM_W   = IN_W + 1;
    localparam int SHIFT_W = 4;
    localparam int BEAT_W  = 8;
    localparam int LANES   = 4;
    localparam int FIFO_W  = LANES * OUT_W + 1;

    localparam int OUT_MAX = (1 << (OUT_W - 1)) - 1;
    localparam int OUT_MIN = -(1 << (OUT_W - 1));

    localparam logic [1:0] SIZE_4  = 2'd0;
    localparam logic [1:0] SIZE_8  = 2'd1;
    localparam logic [1:0] SIZE_16 = 2'd2;
    localparam logic [1:0] SIZE_32 = 2'd3;

    localparam logic [SHIFT_W-1:0] SHIFT_INV_P0 = 4'd7;
    localparam logic [SHIFT_W-1:0] SHIFT_INV_P1 = 4'd12;
    localparam logic [SHIFT_W-1:0] SHIFT_FWD_P0 = 4'd1;
    localparam logic [SHIFT_W-1:0] SHIFT_FWD_P1 = 4'd8;

    typedef struct packed {
        logic [1:0] size;
        logic       inverse;
        logic       pass;
    } mode_t;

    localparam mode_t MODE_RESET = '{size: SIZE_4, inverse: 1'b0, pass: 1'b0};

    typedef struct packed {
        logic                        row_last;
        logic [LANES-1:0][OUT_W-1:0] data;
    } fifo_word_t;

    // Forward shifts grow by one per size step starting from the pass base.
    function automatic logic [SHIFT_W-1:0] shift_sel(input mode_t m);
        if (m.inverse) begin
            return m.pass ? SHIFT_INV_P1 : SHIFT_INV_P0;
        end
        return (m.pass ? SHIFT_FWD_P1 : SHIFT_FWD_P0) + {2'b00, m.size};
    endfunction

    function automatic logic [BEAT_W-1:0] beats_last(input logic [1:0] size);
        case (size)
            SIZE_4:  return 8'd3;
            SIZE_8:  return 8'd15;
            SIZE_16: return 8'd63;
            default: return 8'd255;
        endcase
    endfunction

endpackage

// File: rtl/rec_rnd_clip_if.sv
// Beat bus of the round/clip stage: upstream butterfly beats in, clipped beats out.
interface rec_rnd_clip_if;
    import rec_tq_pkg::*;

    logic                    i_dt_vld;
    logic [1:0]              i_size;
    logic                    i_inverse;
    logic                    i_pass;
    logic signed [IN_W-1:0]  i_data0;
    logic signed [IN_W-1:0]  i_data1;
    logic signed [IN_W-1:0]  i_data2;
    logic signed [IN_W-1:0]  i_data3;
    logic                    o_ready;
    logic                    o_vld;
    logic                    i_rdy;
    logic signed [OUT_W-1:0] o_data0;
    logic signed [OUT_W-1:0] o_data1;
    logic signed [OUT_W-1:0] o_data2;
    logic signed [OUT_W-1:0] o_data3;
    logic                    o_row_last;
    logic                    o_ovf;

    modport master (
        output i_dt_vld, i_size, i_inverse, i_pass,
        output i_data0, i_data1, i_data2, i_data3, i_rdy,
        input  o_ready, o_vld, o_data0, o_data1, o_data2, o_data3,
        input  o_row_last, o_ovf
    );

    modport slave (
        input  i_dt_vld, i_size, i_inverse, i_pass,
        input  i_data0, i_data1, i_data2, i_data3, i_rdy,
        output o_ready, o_vld, o_data0, o_data1, o_data2, o_data3,
        output o_row_last, o_ovf
    );

endinterface

// File: rtl/rec_sync_fifo.sv
// Synchronous FIFO with a registered head: a written word reaches rd_data two
// edges after it is written. count includes the word held in the head register.
module rec_sync_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_vld,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    mem_cnt;
    logic [WIDTH-1:0] head;
    logic             head_vld;
    logic             pop;
    logic             load;
    logic             push;

    assign count   = mem_cnt + CW'(head_vld);
    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = head;
    assign rd_vld  = head_vld;

    // A pop frees the head, so a write while full is still safe in that cycle.
    assign pop  = rd_en & head_vld;
    assign load = (mem_cnt != '0) & (~head_vld | pop);
    assign push = wr_en & (~full | pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            mem_cnt  <= '0;
            head_vld <= 1'b0;
            head     <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (load) begin
                head   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            mem_cnt  <= mem_cnt + CW'(push) - CW'(load);
            head_vld <= load | (head_vld & ~pop);
        end
    end

endmodule

// File: rtl/rec_rnd_clip.sv
// Rounds, shifts and saturates four 28-bit butterfly results per beat to 16 bits,
// tracks block framing and buffers results in an output FIFO.
module rec_rnd_clip
    import rec_tq_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    rec_rnd_clip_if.slave bus
);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic signed [SUM_W-1:0] CLIP_MAX = SUM_W'(OUT_MAX);
    localparam logic signed [SUM_W-1:0] CLIP_MIN = SUM_W'(OUT_MIN);

    function automatic logic signed [SUM_W-1:0] round_add(
        input logic signed [IN_W-1:0] x,
        input logic [SHIFT_W-1:0]     s
    );
        logic signed [SUM_W-1:0] offset;
        offset = SUM_W'(1) << (s - SHIFT_W'(1));
        return $signed({x[IN_W-1], x}) + offset;
    endfunction

    function automatic logic signed [OUT_W-1:0] shift_clip(
        input logic signed [SUM_W-1:0] v,
        input logic [SHIFT_W-1:0]      s
    );
        logic signed [SUM_W-1:0] q;
        q = v >>> s;
        if (q > CLIP_MAX) begin
            return CLIP_MAX[OUT_W-1:0];
        end else if (q < CLIP_MIN) begin
            return CLIP_MIN[OUT_W-1:0];
        end
        return q[OUT_W-1:0];
    endfunction

    logic signed [IN_W-1:0]  din [LANES];
    mode_t                   mode_q;
    mode_t                   mode_in;
    mode_t                   mode_eff;
    logic [BEAT_W-1:0]       beat_cnt;
    logic [SHIFT_W-1:0]      shift_s;
    logic                    last;
    logic                    accept;
    logic                    ovf_q;

    logic signed [SUM_W-1:0] sum_p0 [LANES];
    logic [SHIFT_W-1:0]      shift_p0;
    logic                    last_p0;
    logic                    vld_p0;

    fifo_word_t              wr_word;
    fifo_word_t              rd_word;
    logic [FIFO_W-1:0]       rd_data;
    logic                    fifo_vld;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CNT_W-1:0]        fifo_count;
    logic [CNT_W:0]          occupancy;

    assign din[0] = bus.i_data0;
    assign din[1] = bus.i_data1;
    assign din[2] = bus.i_data2;
    assign din[3] = bus.i_data3;

    assign mode_in  = '{size: bus.i_size, inverse: bus.i_inverse, pass: bus.i_pass};
    // The first beat of a block must already use its own mode, not the stale latch.
    assign mode_eff = (beat_cnt == '0) ? mode_in : mode_q;
    assign shift_s  = shift_sel(mode_eff);
    assign last     = (beat_cnt == beats_last(mode_eff.size));

    assign occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, vld_p0};
    assign bus.o_ready = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign accept      = bus.i_dt_vld & bus.o_ready;
    assign bus.o_ovf   = ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
            mode_q   <= MODE_RESET;
            ovf_q    <= 1'b0;
        end else begin
            if (accept) begin
                beat_cnt <= last ? '0 : beat_cnt + BEAT_W'(1);
                if (beat_cnt == '0) begin
                    mode_q <= mode_in;
                end
            end
            if (bus.i_dt_vld & ~bus.o_ready) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Stage 1 -> p0: add rounding offset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= accept;
        end
        for (int i = 0; i < LANES; i++) begin
            sum_p0[i] <= round_add(din[i], shift_s);
        end
        shift_p0 <= shift_s;
        last_p0  <= last;
    end

    // Stage 2: shift and clip straight into the FIFO write port.
    always_comb begin
        wr_word          = '0;
        wr_word.row_last = last_p0;
        for (int i = 0; i < LANES; i++) begin
            wr_word.data[i] = shift_clip(sum_p0[i], shift_p0);
        end
    end

    rec_sync_fifo #(
        .WIDTH (FIFO_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld_p0),
        .wr_data (wr_word),
        .rd_en   (bus.i_rdy & ~fifo_empty),
        .rd_data (rd_data),
        .rd_vld  (fifo_vld),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rd_word        = rd_data;
    assign bus.o_vld      = fifo_vld;
    assign bus.o_row_last = fifo_vld & rd_word.row_last;
    assign bus.o_data0    = $signed(rd_word.data[0]);
    assign bus.o_data1    = $signed(rd_word.data[1]);
    assign bus.o_data2    = $signed(rd_word.data[2]);
    assign bus.o_data3    = $signed(rd_word.data[3]);

endmodule

// File: tb/tb_rec_rnd_clip.sv
// Directed bench for rec_rnd_clip: rounding, saturation, framing, backpressure,
// overflow and mid-block reset with hand-computed expected results.
module tb_rec_rnd_clip;
    import rec_tq_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rec_rnd_clip_if bus ();

    rec_rnd_clip #(.FIFO_DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic signed [15:0] d0;
        logic signed [15:0] d1;
        logic signed [15:0] d2;
        logic signed [15:0] d3;
        logic               last;
        int                 t;
    } beat_t;

    beat_t outq[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && bus.o_vld && bus.i_rdy) begin
            outq.push_back('{bus.o_data0, bus.o_data1, bus.o_data2, bus.o_data3, bus.o_row_last, cyc});
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sz, input logic inv, input logic ps,
                         input int d0, input int d1, input int d2, input int d3);
        bus.i_size    = sz;
        bus.i_inverse = inv;
        bus.i_pass    = ps;
        bus.i_data0   = IN_W'(d0);
        bus.i_data1   = IN_W'(d1);
        bus.i_data2   = IN_W'(d2);
        bus.i_data3   = IN_W'(d3);
    endtask

    task automatic send(input logic [1:0] sz, input logic inv, input logic ps,
                        input int d0, input int d1, input int d2, input int d3);
        int g;
        g = 0;
        while (!bus.o_ready && g < 200) begin
            step();
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: o_ready observed 0 expected 1");
        end
        drive(sz, inv, ps, d0, d1, d2, d3);
        bus.i_dt_vld = 1'b1;
        step();
        bus.i_dt_vld = 1'b0;
    endtask

    task automatic wait_q(input int n);
        int g;
        g = 0;
        while (outq.size() < n && g < 300) begin
            step();
            g++;
        end
        check("out_count", outq.size(), n);
    endtask

    initial begin
        int acc;
        int e;

        rst          = 1'b1;
        bus.i_dt_vld = 1'b0;
        bus.i_rdy    = 1'b1;
        drive(2'd0, 1'b0, 1'b0, 0, 0, 0, 0);
        step(3);
        check("rst_vld", bus.o_vld, 0);
        check("rst_last", bus.o_row_last, 0);
        check("rst_ovf", bus.o_ovf, 0);
        check("rst_data0", bus.o_data0, 0);
        rst = 1'b0;
        check("rst_ready", bus.o_ready, 1);

        // Rounding, inverse pass 0 (S=7), with latency check
        send(2'd0, 1'b1, 1'b0, 191, -64, -65, 0);
        check("lat_c1", bus.o_vld, 0);
        step();
        check("lat_c2", bus.o_vld, 0);
        step();
        check("lat_c3", bus.o_vld, 1);
        check("rnd_d0", bus.o_data0, 1);
        check("rnd_d1", bus.o_data1, 0);
        check("rnd_d2", bus.o_data2, -1);
        check("rnd_d3", bus.o_data3, 0);
        for (int i = 0; i < 3; i++) send(2'd0, 1'b1, 1'b0, 0, 0, 0, 0);
        wait_q(4);
        check("rnd_last0", outq[0].last, 0);
        check("rnd_last3", outq[3].last, 1);
        outq.delete();

        // Saturation, inverse pass 1 (S=12)
        send(2'd0, 1'b1, 1'b1, 134217727, -134217728, 4095, -2049);
        for (int i = 0; i < 3; i++) send(2'd0, 1'b1, 1'b1, 0, 0, 0, 0);
        wait_q(4);
        check("sat_d0", outq[0].d0, 32767);
        check("sat_d1", outq[0].d1, -32768);
        check("sat_d2", outq[0].d2, 1);
        check("sat_d3", outq[0].d3, -1);
        check("sat_z3", outq[3].d0, 0);
        check("sat_last", outq[3].last, 1);
        outq.delete();

        // Framing: 4x4 forward pass 0 (S=1), then 8x8 (S=2) with mid-block mode noise
        for (int i = 0; i < 4; i++) send(2'd0, 1'b0, 1'b0, 5, 5, 5, 5);
        send(2'd1, 1'b0, 1'b0, 5, 200000, -200000, 5);
        for (int i = 0; i < 15; i++) send(2'd0, 1'b1, 1'b1, 5, 5, 5, 5);
        wait_q(20);
        for (int i = 0; i < 20; i++) begin
            e = (i < 4) ? 3 : 1;
            check($sformatf("frm%0d_d0", i), outq[i].d0, e);
            check($sformatf("frm%0d_d3", i), outq[i].d3, e);
            check($sformatf("frm%0d_d1", i), outq[i].d1, (i == 4) ? 32767 : e);
            check($sformatf("frm%0d_d2", i), outq[i].d2, (i == 4) ? -32768 : e);
            check($sformatf("frm%0d_last", i), outq[i].last, (i == 3 || i == 19) ? 1 : 0);
        end
        outq.delete();

        // Backpressure: forward pass 1 (S=8), lane0 = k*256 -> k
        bus.i_rdy = 1'b0;
        acc = 0;
        for (int k = 0; k < 14; k++) begin
            if (bus.o_ready) begin
                acc++;
                drive(2'd0, 1'b0, 1'b1, acc * 256, -acc * 256, 0, 0);
                bus.i_dt_vld = 1'b1;
            end else begin
                bus.i_dt_vld = 1'b0;
            end
            step();
        end
        bus.i_dt_vld = 1'b0;
        check("bp_accepted", acc, 8);
        check("bp_ready", bus.o_ready, 0);
        check("bp_ovf", bus.o_ovf, 0);
        check("bp_hold_vld", bus.o_vld, 1);
        step(3);
        check("bp_hold_d0", bus.o_data0, 1);

        // Overflow: beat offered while not ready must be dropped
        drive(2'd0, 1'b0, 1'b1, 99 * 256, 0, 0, 0);
        bus.i_dt_vld = 1'b1;
        step();
        bus.i_dt_vld = 1'b0;
        check("ovf_set", bus.o_ovf, 1);
        bus.i_rdy = 1'b1;
        wait_q(8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bp%0d_d0", i), outq[i].d0, i + 1);
            check($sformatf("bp%0d_d1", i), outq[i].d1, -(i + 1));
            check($sformatf("bp%0d_last", i), outq[i].last, (i == 3 || i == 7) ? 1 : 0);
            check($sformatf("bp%0d_gap", i), outq[i].t - outq[0].t, i);
        end
        step(6);
        check("ovf_dropped", outq.size(), 8);
        check("ovf_sticky", bus.o_ovf, 1);
        outq.delete();

        // Reset mid-block after beat 2
        send(2'd0, 1'b0, 1'b0, 5, 5, 5, 5);
        send(2'd0, 1'b0, 1'b0, 5, 5, 5, 5);
        rst = 1'b1;
        step();
        check("mid_vld", bus.o_vld, 0);
        check("mid_last", bus.o_row_last, 0);
        check("mid_ovf", bus.o_ovf, 0);
        check("mid_d0", bus.o_data0, 0);
        check("mid_d1", bus.o_data1, 0);
        check("mid_d2", bus.o_data2, 0);
        check("mid_d3", bus.o_data3, 0);
        rst = 1'b0;
        check("mid_ready", bus.o_ready, 1);
        outq.delete();
        for (int i = 0; i < 4; i++) send(2'd0, 1'b0, 1'b0, 7, 7, 7, 7);
        wait_q(4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mid%0d_d0", i), outq[i].d0, 4);
            check($sformatf("mid%0d_last", i), outq[i].last, (i == 3) ? 1 : 0);
        end
        step(4);
        check("mid_no_extra", outq.size(), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
